// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, zero-register index and packed-port slice helpers
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int ZERO_IDX       = 0;

    // Low bit of port idx inside a packed bus of width-bit fields
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: per-entry write enables and data from packed write ports, lowest port wins
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_WR     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic [NUM_WR-1:0]                               wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]                    wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]                    wr_data,
    output logic [2**ADDR_WIDTH-1:0]                        we,
    output logic [2**ADDR_WIDTH-1:0]                        clr,
    output logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]        wd,
    output logic                                            collision
);

    // Scan ports low to high: first claimant of an entry wins, later ones only flag a collision.
    // clr marks every entry touched by any enabled port, which is what clears the scoreboard.
    always_comb begin
        clr       = '0;
        wd        = '0;
        collision = 1'b0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
                if (clr[wr_addr[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH]]) begin
                    collision = 1'b1;
                end else begin
                    clr[wr_addr[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b1;
                    wd[wr_addr[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH]]  = wr_data[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end
        we = clr;
        if (ZERO_REG != 0) we[ZERO_IDX] = 1'b0;
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with bypass, zero register and pending scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic                         issue_en,
    input  logic [ADDR_WIDTH-1:0]        issue_addr,
    output logic                         wr_conflict
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0]                 we, clr, set, pending, pend_nx;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] wd, mem, mem_nx;
    logic                             collision;

    regfile_wr_arb #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WR     (NUM_WR),
        .ZERO_REG   (ZERO_REG)
    ) u_arb (
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .we        (we),
        .clr       (clr),
        .wd        (wd),
        .collision (collision)
    );

    // Post-edge array and scoreboard; an issue beats a same-cycle clear of the same entry
    always_comb begin
        set = '0;
        if (issue_en && !(ZERO_REG != 0 && issue_addr == ADDR_WIDTH'(ZERO_IDX))) set[issue_addr] = 1'b1;
        for (int e = 0; e < DEPTH; e++) mem_nx[e] = we[e] ? wd[e] : mem[e];
        pend_nx = (pending & ~clr) | set;
    end

    // Register array, pending vector and collision pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem         <= '0;
            pending     <= '0;
            wr_conflict <= 1'b0;
        end else begin
            mem         <= mem_nx;
            pending     <= pend_nx;
            wr_conflict <= collision;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] q_data;
        logic                  q_busy;
        assign ra = rd_addr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
        // Registered read: write-first view when bypassing, pre-edge view otherwise
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_data <= '0;
                q_busy <= 1'b0;
            end else begin
                q_data <= (BYPASS != 0) ? mem_nx[ra] : mem[ra];
                q_busy <= (BYPASS != 0) ? pend_nx[ra] : pending[ra];
            end
        end
        assign rd_data[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] = q_data;
        assign rd_busy[i] = q_busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of write-first and read-first register file instances
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic [63:0] rd_data, rd_data0;
    logic [1:0]  rd_busy, rd_busy0;
    logic        wr_conflict, wr_conflict0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1)) dut (
        .clk (clk), .rst_n (rst_n), .rd_addr (rd_addr), .rd_data (rd_data), .rd_busy (rd_busy),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .issue_en (issue_en), .issue_addr (issue_addr), .wr_conflict (wr_conflict)
    );

    regfile_mp #(.BYPASS(0)) dut0 (
        .clk (clk), .rst_n (rst_n), .rd_addr (rd_addr), .rd_data (rd_data0), .rd_busy (rd_busy0),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .issue_en (issue_en), .issue_addr (issue_addr), .wr_conflict (wr_conflict0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle();
        wr_en    = '0;
        issue_en = 1'b0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p]             = 1'b1;
        wr_addr[p*5 +: 5]    = a;
        wr_data[p*32 +: 32]  = d;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #2;
        check("rst_data", rd_data[31:0], 32'h0);
        check("rst_busy", {30'd0, rd_busy}, 32'h0);
        check("rst_conf", {31'd0, wr_conflict}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // write r5, issue r6, read r5/r6 in the same cycle
        wr(0, 5'd5, 32'hDEADBEEF);
        issue_en = 1'b1; issue_addr = 5'd6;
        rd(5'd5, 5'd6);
        tick();
        check("byp_r5", rd_data[31:0], 32'hDEADBEEF);
        check("rf_r5", rd_data0[31:0], 32'h0);
        check("byp_busy_r6", {31'd0, rd_busy[1]}, 32'h1);
        // asynchronous reset mid-cycle with a write in flight
        idle();
        wr(0, 5'd5, 32'h12345678);
        #1 rst_n = 1'b0;
        #1;
        check("arst_data", rd_data[31:0], 32'h0);
        check("arst_busy", {30'd0, rd_busy}, 32'h0);
        check("arst_conf", {31'd0, wr_conflict}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        rd(5'd5, 5'd6);
        tick();
        check("post_rst_r5", rd_data[31:0], 32'h0);
        check("post_rst_busy_r6", {31'd0, rd_busy[1]}, 32'h0);
        // two ports, distinct addresses
        wr(0, 5'd3, 32'h11);
        wr(1, 5'd4, 32'h22);
        tick();
        check("basic_conf", {31'd0, wr_conflict}, 32'h0);
        idle();
        rd(5'd3, 5'd4);
        tick();
        check("basic_r3", rd_data[31:0], 32'h11);
        check("basic_r4", rd_data[63:32], 32'h22);
        check("basic_r3_rf", rd_data0[31:0], 32'h11);
        rd(5'd4, 5'd4);
        tick();
        check("dup_p0", rd_data[31:0], 32'h22);
        check("dup_p1", rd_data[63:32], 32'h22);
        // collision on r7: port 0 wins, pulse lasts one cycle
        wr(0, 5'd7, 32'hAA);
        wr(1, 5'd7, 32'hBB);
        tick();
        check("coll_conf", {31'd0, wr_conflict}, 32'h1);
        idle();
        rd(5'd7, 5'd0);
        tick();
        check("coll_conf_off", {31'd0, wr_conflict}, 32'h0);
        check("coll_r7", rd_data[31:0], 32'hAA);
        check("coll_r7_rf", rd_data0[31:0], 32'hAA);
        // write-first versus read-first on r9
        wr(0, 5'd9, 32'h55);
        rd(5'd9, 5'd0);
        tick();
        check("byp_r9", rd_data[31:0], 32'h55);
        check("rf_r9_old", rd_data0[31:0], 32'h0);
        idle();
        tick();
        check("rf_r9_new", rd_data0[31:0], 32'h55);
        // zero register: writes, issue and collision on index 0
        wr(0, 5'd0, 32'hFFFF);
        wr(1, 5'd0, 32'h1234);
        issue_en = 1'b1; issue_addr = 5'd0;
        rd(5'd0, 5'd0);
        tick();
        check("zero_data", rd_data[31:0], 32'h0);
        check("zero_busy", {30'd0, rd_busy}, 32'h0);
        check("zero_conf", {31'd0, wr_conflict}, 32'h1);
        idle();
        tick();
        check("zero_data2", rd_data0[31:0], 32'h0);
        check("zero_busy2", {30'd0, rd_busy0}, 32'h0);
        // scoreboard: issue r12, then a write clears it
        issue_en = 1'b1; issue_addr = 5'd12;
        rd(5'd12, 5'd12);
        tick();
        check("sb_set_byp", {31'd0, rd_busy[0]}, 32'h1);
        check("sb_set_rf", {31'd0, rd_busy0[0]}, 32'h0);
        idle();
        tick();
        check("sb_hold_rf", {31'd0, rd_busy0[1]}, 32'h1);
        wr(1, 5'd12, 32'h77);
        tick();
        check("sb_clr_byp", {31'd0, rd_busy[0]}, 32'h0);
        check("sb_clr_rf_pre", {31'd0, rd_busy0[0]}, 32'h1);
        idle();
        tick();
        check("sb_clr_rf", {31'd0, rd_busy0[0]}, 32'h0);
        // same-cycle issue and write: set wins
        wr(0, 5'd12, 32'h88);
        issue_en = 1'b1; issue_addr = 5'd12;
        tick();
        check("sb_both_byp", {31'd0, rd_busy[0]}, 32'h1);
        idle();
        tick();
        check("sb_both_rf", {31'd0, rd_busy0[0]}, 32'h1);
        check("sb_both_data", rd_data[31:0], 32'h88);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
